dmem_mmio: RTL
==============

# dmem_mmio

Data-side memory system for the single-cycle MIPS core. Consumes the core's `memwrite`, `aluout` (address) and `writedata` and returns `readdata` in the same cycle. Holds a word-addressed data RAM plus a memory-mapped peripheral page with a compare timer and a 4-entry byte TX FIFO that drains over a valid/ready port.

## Interface
- `RAM_AW`, 6: RAM address bits; the RAM holds 2^RAM_AW 32-bit words.
- `FIFO_DEPTH`, 4: TX FIFO entries. Fixed at 4; count field is 3 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `memwrite`  in  1  store strobe from core.
- `addr`  in  32  byte address (core `aluout`); bits [1:0] ignored.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational from `addr`.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_data`  out  8  FIFO head byte.
- `tx_ready`  in  1  consumer accepts the head when `tx_valid & tx_ready`.
- `timer_irq`  out  1  `expired & irq_en`.

## Operation
- Decode:
  - RAM when `addr[31:16]==16'h0000` and `addr[15:RAM_AW+2]==0`; index is `addr[RAM_AW+1:2]`.
  - MMIO when `addr[31:8]==24'hFFFF00`.
  - All other addresses are unmapped: read 0, writes ignored.
- RAM: asynchronous read; write on clock edge when `memwrite` and RAM hit; no reset (contents X until written).
- MMIO registers (word offsets):
  - 0x00 TIMER_COUNT, RW.
  - 0x04 TIMER_CTRL: bit0 `en` RW, bit1 `expired` read / write-1-to-clear, bit2 `irq_en` RW; other bits read 0.
  - 0x08 TIMER_CMP, RW.
  - 0x10 TX_DATA: write pushes `writedata[7:0]`; reads 0.
  - 0x14 TX_STATUS, RO: bit0 `full`, bit1 `empty`, bit2 `ovf` (write-1-to-clear), bits[5:3] count 0..4.
  - Other MMIO offsets read 0; writes ignored.
- Timer, per cycle, in priority order:
  1. Core write to TIMER_COUNT loads `writedata`.
  2. Otherwise, if `en` and count==CMP: count<=0 and `expired` is set.
  3. Otherwise, if `en`: count<=count+1, wrapping mod 2^32.
  4. Otherwise hold.
- If `expired` is set and W1C-cleared in the same cycle, set wins.
- TX FIFO: circular buffer with read and write pointers plus a 3-bit count.
  - Pop on `tx_valid & tx_ready`.
  - Push on a TX_DATA write; accepted if count<4 or a pop occurs in the same cycle.
  - A rejected push drops the byte and sets sticky `ovf`. If set and W1C-cleared in the same cycle, set wins.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - `tx_data` is the head entry and is valid only while `tx_valid`.

## Timing
- Loads are zero latency: `readdata` is combinational, as the single-cycle core requires.
- Reads of TIMER_COUNT, TX_STATUS and TIMER_CTRL return the pre-edge register value.
- All stores and FIFO/timer updates take effect on the `clk` rising edge.
- Reset (`reset==0` at an edge):
  - Timer: count=0, CMP=32'hFFFFFFFF, `en`=`irq_en`=`expired`=0.
  - FIFO: pointers=0, count=0, `ovf`=0.
  - Outputs after reset: `tx_valid`=0, `timer_irq`=0.
  - RAM is untouched.
- Reset asserted mid-operation overrides any concurrent store or pop. FIFO contents are discarded and `tx_valid` falls on that edge.
- `tx_valid` rises the cycle after the first accepted push. `tx_data` must be held stable while `tx_valid & !tx_ready`.
- `timer_irq` rises on the edge after the cycle in which count==CMP with `en`=1.

## Test plan
- RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> 0xDEADBEEF. Load 0x0000_0014 after writing 0x1 there -> 0x1. Store to 0x1000_0000 -> ignored, and a load there returns 0.
- Timer: write CMP=3, CTRL=0x5, count=0. Read count over successive cycles -> 1,2,3,0. `expired`=1 and `timer_irq`=1 after the wrap. Write CTRL=0x7 -> `expired` clears while `en` and `irq_en` stay 1.
- FIFO fill/overflow: with `tx_ready`=0, push 0x11,0x22,0x33,0x44 -> STATUS=0x21 (count4, full). Push 0x55 -> dropped, `ovf`=1, STATUS=0x25. Raise `tx_ready` -> drains 0x11,0x22,0x33,0x44 in order, then `tx_valid`=0 and STATUS bit1=1.
- Simultaneous push and pop when full -> accepted, count stays 4, `ovf` stays 0, new byte emerges last.
- Reset mid-operation: hold `reset`=0 for one edge while the FIFO holds 2 entries and the timer is running -> `tx_valid`=0, count=0, CTRL reads 0, CMP reads 0xFFFFFFFF. RAM retains the previously stored 0xDEADBEEF.
- Same-cycle set/clear: W1C of `expired` in the cycle where count==CMP -> `expired` remains 1.

Source files
------------

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus MMIO page (compare timer, 4-entry TX FIFO).
// Ports: clk/reset (sync, active-low), memwrite/addr/writedata/readdata
// core bus, tx_valid/tx_data/tx_ready byte stream, timer_irq.
module dmem_mmio #(
    parameter int RAM_AW     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    logic [31:0] ram [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ridx;
    logic ram_hit, mmio_hit;
    logic [5:0] off;

    logic sel_cnt, sel_ctrl, sel_cmp, sel_txd, sel_stat;

    logic [31:0] tcount, tcmp;
    logic en, irq_en, expired;
    logic tmatch;

    logic [7:0] fifo [0:3];
    logic [1:0] rptr, wptr;
    logic [2:0] fcount;
    logic ovf;
    logic fifo_full, fifo_empty;
    logic pop, push_req, push, drop;

    logic unused;

    assign unused = ^addr[1:0];

    assign ram_hit  = (addr[31:16] == 16'h0000) &&
                      ((addr[15:0] >> (RAM_AW + 2)) == 16'h0000);
    assign mmio_hit = (addr[31:8] == 24'hFFFF00);
    assign ridx     = addr[RAM_AW+1:2];
    assign off      = addr[7:2];

    assign sel_cnt  = mmio_hit && (off == 6'd0);
    assign sel_ctrl = mmio_hit && (off == 6'd1);
    assign sel_cmp  = mmio_hit && (off == 6'd2);
    assign sel_txd  = mmio_hit && (off == 6'd4);
    assign sel_stat = mmio_hit && (off == 6'd5);

    assign tmatch = en && (tcount == tcmp);

    assign fifo_full  = (fcount == 3'(FIFO_DEPTH));
    assign fifo_empty = (fcount == 3'd0);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo[rptr];
    assign pop        = tx_valid && tx_ready;
    assign push_req   = memwrite && sel_txd;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push;

    assign timer_irq = expired && irq_en;

    always_comb begin
        readdata = 32'h0;
        if (ram_hit) begin
            readdata = ram[ridx];
        end else if (mmio_hit) begin
            case (off)
                6'd0:    readdata = tcount;
                6'd1:    readdata = {29'h0, irq_en, expired, en};
                6'd2:    readdata = tcmp;
                6'd5:    readdata = {26'h0, fcount, ovf,
                                     fifo_empty, fifo_full};
                default: readdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && memwrite && ram_hit) begin
            ram[ridx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo[wptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcount  <= 32'h0;
            tcmp    <= 32'hFFFF_FFFF;
            en      <= 1'b0;
            irq_en  <= 1'b0;
            expired <= 1'b0;
            rptr    <= 2'd0;
            wptr    <= 2'd0;
            fcount  <= 3'd0;
            ovf     <= 1'b0;
        end else begin
            if (memwrite && sel_cnt) begin
                tcount <= writedata;
            end else if (tmatch) begin
                tcount <= 32'h0;
            end else if (en) begin
                tcount <= tcount + 32'd1;
            end

            if (memwrite && sel_cmp) begin
                tcmp <= writedata;
            end

            if (memwrite && sel_ctrl) begin
                en     <= writedata[0];
                irq_en <= writedata[2];
            end

            // A count write pre-empts the compare, so no expiry then.
            if (tmatch && !(memwrite && sel_cnt)) begin
                expired <= 1'b1;
            end else if (memwrite && sel_ctrl && writedata[1]) begin
                expired <= 1'b0;
            end

            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fcount <= fcount + 3'd1;
                2'b01:   fcount <= fcount - 3'd1;
                default: fcount <= fcount;
            endcase

            if (drop) begin
                ovf <= 1'b1;
            end else if (memwrite && sel_stat && writedata[2]) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
